// File: rtl/crypt_pkg.sv
// Shared types and constants for the crypter output packer.
// Holds the packer FSM encoding and the per-block bit budget.
package crypt_pkg;

  localparam int BLK_W    = 32;
  localparam int BYTE_W   = 8;
  localparam int MIN_NLEN = 2;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    SEND,
    WAIT_BUSY,
    WAIT_IDLE,
    FLUSH_CHK
  } state_e;

  // Decrypt blocks carry n_len-1 payload bits; out-of-range keys are clamped.
  function automatic logic [5:0] bits_per_block(
    input logic       mode,
    input logic [5:0] n_len
  );
    if (mode)
      return 6'(BLK_W);
    if (n_len < 6'(MIN_NLEN))
      return '0;
    if (n_len > 6'(BLK_W + 1))
      return 6'(BLK_W);
    return n_len - 6'd1;
  endfunction

endpackage

// File: rtl/crypter_out_packer_byte_assembler.sv
// Collects serial bits LSB first into one byte.
// Bits above the fill count are masked off on the byte output.
module byte_assembler
  import crypt_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              bit_in,
  input  logic              shift_en,
  input  logic              clear,
  output logic              full,
  output logic [BYTE_W-1:0] byte_out,
  output logic [3:0]        cnt
);

  logic [BYTE_W-1:0] acc_q, acc_d;
  logic [3:0]        acc_cnt_q, acc_cnt_d;

  always_comb begin
    acc_d     = acc_q;
    acc_cnt_d = acc_cnt_q;
    if (clear) begin
      acc_d     = '0;
      acc_cnt_d = '0;
    end else if (shift_en && acc_cnt_q < 4'(BYTE_W)) begin
      acc_d[acc_cnt_q[2:0]] = bit_in;
      acc_cnt_d             = acc_cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q     <= '0;
      acc_cnt_q <= '0;
    end else begin
      acc_q     <= acc_d;
      acc_cnt_q <= acc_cnt_d;
    end
  end

  // Asserted when the shift in progress completes the byte.
  assign full = (acc_cnt_q == 4'(BYTE_W - 1));
  assign cnt  = acc_cnt_q;

  always_comb begin
    byte_out = '0;
    for (int i = 0; i < BYTE_W; i++)
      byte_out[i] = acc_q[i] & (4'(i) < acc_cnt_q);
  end

endmodule

// File: rtl/crypter_out_packer.sv
// Serialises FME result blocks into UART bytes, LSB first.
// Byte boundaries carry across blocks; eot flushes a padded partial byte.
module crypter_out_packer
  import crypt_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              mode,
  input  logic [5:0]        n_len,
  input  logic [BLK_W-1:0]  fme_result,
  input  logic              fme_done,
  input  logic              eot,
  output logic              busy,
  input  logic              ready_out,
  output logic              start_out,
  output logic [BYTE_W-1:0] data_out,
  output logic              eot_done
);

  state_e            state_q, state_d;
  logic [BLK_W-1:0]  blk_sr_q, blk_sr_d;
  logic [5:0]        bit_cnt_q, bit_cnt_d;
  logic              eot_pend_q, eot_pend_d;
  logic              flush_q, flush_d;
  logic              start_out_q, start_out_d;
  logic              eot_done_q, eot_done_d;
  logic [BYTE_W-1:0] data_out_q, data_out_d;

  logic              shift_en;
  logic              acc_clr;
  logic              acc_full;
  logic [BYTE_W-1:0] acc_byte;
  logic [3:0]        acc_cnt;

  logic [5:0]        blk_bits;
  logic              load;
  logic              acc_empty;
  logic              last_bit;
  logic              eot_seen;

  assign blk_bits  = bits_per_block(mode, n_len);
  assign load      = fme_done && (blk_bits != '0);
  assign acc_empty = (acc_cnt == '0);
  assign last_bit  = (bit_cnt_q == 6'd1);
  assign eot_seen  = eot_pend_q | eot;

  byte_assembler u_asm (
    .clk      (clk),
    .rst      (rst),
    .bit_in   (blk_sr_q[0]),
    .shift_en (shift_en),
    .clear    (acc_clr),
    .full     (acc_full),
    .byte_out (acc_byte),
    .cnt      (acc_cnt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (load)
            state_d = SHIFT;
          else if (eot && !acc_empty)
            state_d = SEND;
        end
        SHIFT: begin
          if (acc_full)
            state_d = SEND;
          else if (last_bit)
            state_d = eot_seen ? FLUSH_CHK : IDLE;
        end
        SEND: begin
          if (ready_out)
            state_d = WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (!ready_out)
            state_d = WAIT_IDLE;
        end
        WAIT_IDLE: begin
          if (ready_out)
            state_d = (bit_cnt_q != '0) ? SHIFT : IDLE;
        end
        FLUSH_CHK: begin
          state_d = acc_empty ? IDLE : SEND;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    blk_sr_d    = blk_sr_q;
    bit_cnt_d   = bit_cnt_q;
    eot_pend_d  = eot_seen;
    flush_d     = flush_q;
    start_out_d = 1'b0;
    data_out_d  = data_out_q;
    eot_done_d  = 1'b0;
    shift_en    = 1'b0;
    acc_clr     = 1'b0;
    if (start) begin
      blk_sr_d   = '0;
      bit_cnt_d  = '0;
      eot_pend_d = 1'b0;
      flush_d    = 1'b0;
      data_out_d = '0;
      acc_clr    = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          eot_pend_d = 1'b0;
          if (load) begin
            blk_sr_d   = fme_result;
            bit_cnt_d  = blk_bits;
            eot_pend_d = eot;
          end else if (eot) begin
            // A lone eot either flushes the partial byte or ends at once.
            if (acc_empty)
              eot_done_d = 1'b1;
            else
              flush_d = 1'b1;
          end
        end
        SHIFT: begin
          shift_en  = 1'b1;
          blk_sr_d  = blk_sr_q >> 1;
          bit_cnt_d = bit_cnt_q - 6'd1;
        end
        SEND: begin
          if (ready_out) begin
            start_out_d = 1'b1;
            data_out_d  = acc_byte;
            acc_clr     = 1'b1;
          end
        end
        WAIT_IDLE: begin
          if (ready_out && bit_cnt_q == '0 && (flush_q || eot_seen)) begin
            eot_done_d = 1'b1;
            flush_d    = 1'b0;
            eot_pend_d = 1'b0;
          end
        end
        FLUSH_CHK: begin
          if (acc_empty) begin
            eot_done_d = 1'b1;
            eot_pend_d = 1'b0;
          end else begin
            flush_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blk_sr_q    <= '0;
      bit_cnt_q   <= '0;
      eot_pend_q  <= 1'b0;
      flush_q     <= 1'b0;
      start_out_q <= 1'b0;
      data_out_q  <= '0;
      eot_done_q  <= 1'b0;
    end else begin
      blk_sr_q    <= blk_sr_d;
      bit_cnt_q   <= bit_cnt_d;
      eot_pend_q  <= eot_pend_d;
      flush_q     <= flush_d;
      start_out_q <= start_out_d;
      data_out_q  <= data_out_d;
      eot_done_q  <= eot_done_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign start_out = start_out_q;
  assign data_out  = data_out_q;
  assign eot_done  = eot_done_q;

endmodule

// File: tb/tb_crypter_out_packer.sv
// Scoreboard bench for crypter_out_packer with a bit-stream model.
// A UART model answers each start_out with a busy window.
module tb_crypter_out_packer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        mode;
  logic [5:0]  n_len;
  logic [31:0] fme_result;
  logic        fme_done;
  logic        eot;
  logic        busy;
  logic        ready_out;
  logic        start_out;
  logic [7:0]  data_out;
  logic        eot_done;

  crypter_out_packer dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .mode       (mode),
    .n_len      (n_len),
    .fme_result (fme_result),
    .fme_done   (fme_done),
    .eot        (eot),
    .busy       (busy),
    .ready_out  (ready_out),
    .start_out  (start_out),
    .data_out   (data_out),
    .eot_done   (eot_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int seen_bytes = 0;
  int exp_eot = 0;
  int gap_fixed = 0;
  logic hold = 1'b0;
  logic [7:0] exp_q[$];

  // Reference model: a plain LSB-first bit stream cut into bytes.
  logic [7:0] pacc = '0;
  int pcnt = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic m_push_bit(input logic b);
    pacc[pcnt] = b;
    pcnt++;
    if (pcnt == 8) begin
      exp_q.push_back(pacc);
      pacc = '0;
      pcnt = 0;
    end
  endtask

  task automatic m_block(input logic md, input int nl, input logic [31:0] v);
    int nb;
    if (md)
      nb = 32;
    else if (nl < 2)
      nb = 0;
    else
      nb = (nl - 1 > 32) ? 32 : nl - 1;
    for (int i = 0; i < nb; i++)
      m_push_bit(v[i]);
  endtask

  task automatic m_eot();
    if (pcnt > 0) begin
      exp_q.push_back(pacc);
      pacc = '0;
      pcnt = 0;
    end
    exp_eot++;
  endtask

  task automatic m_clear();
    pacc = '0;
    pcnt = 0;
  endtask

  // Monitor: every byte and eot_done is matched against the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      if (start_out) begin
        seen_bytes++;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_byte: got %02h expected none", data_out);
        end else begin
          chk("byte", 32'(data_out), 32'(exp_q.pop_front()));
        end
      end
      if (eot_done) begin
        if (exp_eot == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_eot_done: got 1 expected 0");
        end else begin
          exp_eot--;
          chk("eot_after_bytes", 32'(exp_q.size()), 32'd0);
        end
      end
    end
  end

  // UART model: goes busy after each byte, then returns to ready.
  initial begin
    ready_out = 1'b1;
    forever begin
      @(negedge clk);
      if (start_out && !rst) begin
        ready_out = 1'b0;
        repeat (gap_fixed > 0 ? gap_fixed : int'($urandom_range(1, 6)))
          @(negedge clk);
      end
      ready_out = !hold;
    end
  end

  task automatic issue_block(input logic md, input int nl,
                             input logic [31:0] v, input logic es);
    @(negedge clk);
    mode       = md;
    n_len      = 6'(nl);
    fme_result = v;
    fme_done   = 1'b1;
    eot        = es;
    m_block(md, nl, v);
    if (es)
      m_eot();
    @(negedge clk);
    fme_done = 1'b0;
    eot      = 1'b0;
  endtask

  task automatic issue_eot();
    @(negedge clk);
    eot = 1'b1;
    m_eot();
    @(negedge clk);
    eot = 1'b0;
  endtask

  task automatic issue_start();
    @(negedge clk);
    start = 1'b1;
    m_clear();
    exp_q.delete();
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input int bound);
    int n = 0;
    while ((busy || exp_q.size() != 0 || exp_eot != 0) && n < bound) begin
      @(negedge clk);
      n++;
    end
    if (n >= bound) begin
      checks++;
      failures++;
      $display("FAIL wait_idle_timeout: got busy=%0d pending=%0d expected idle",
               busy, exp_q.size());
    end
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int sb, c0, d0, bad;
    rst = 1'b1; start = 1'b0; mode = 1'b0; n_len = 6'd0;
    fme_result = '0; fme_done = 1'b0; eot = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_start_out", 32'(start_out), 32'd0);
    chk("rst_data_out", 32'(data_out), 32'd0);
    chk("rst_eot_done", 32'(eot_done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // 1: encrypt, fixed UART gap, first-byte latency
    gap_fixed = 5;
    sb = seen_bytes;
    @(negedge clk);
    mode = 1'b1; n_len = 6'd17; fme_result = 32'h11223344; fme_done = 1'b1;
    m_block(1'b1, 17, 32'h11223344);
    c0 = cyc;
    @(negedge clk);
    fme_done = 1'b0;
    for (int i = 0; i < 50 && !start_out; i++) @(negedge clk);
    chk("t1_latency", 32'(cyc - c0), 32'd10);
    wait_idle(500);
    chk("t1_bytes", 32'(seen_bytes - sb), 32'd4);
    chk("t1_busy", 32'(busy), 32'd0);

    // 2: decrypt n_len=9 -> one full byte, no eot_done
    sb = seen_bytes;
    issue_block(1'b0, 9, 32'h000000A5, 1'b0);
    wait_idle(500);
    repeat (5) @(negedge clk);
    chk("t2_bytes", 32'(seen_bytes - sb), 32'd1);

    // 3: two nibbles join into 0xC3, then eot
    sb = seen_bytes;
    issue_block(1'b0, 5, 32'h3, 1'b0);
    wait_idle(500);
    issue_block(1'b0, 5, 32'hC, 1'b0);
    wait_idle(500);
    issue_eot();
    wait_idle(500);
    chk("t3_bytes", 32'(seen_bytes - sb), 32'd1);

    // 4: eot together with fme_done -> padded flush
    sb = seen_bytes;
    issue_block(1'b0, 5, 32'h7, 1'b1);
    wait_idle(500);
    chk("t4_bytes", 32'(seen_bytes - sb), 32'd1);

    // 5: UART stalls in SEND
    gap_fixed = 0;
    hold = 1'b1;
    repeat (2) @(negedge clk);
    issue_block(1'b1, 32, 32'h55AA33CC, 1'b0);
    repeat (12) @(negedge clk);
    sb = seen_bytes;
    d0 = int'(data_out);
    bad = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (start_out || !busy || int'(data_out) != d0) bad++;
    end
    chk("t5_stall", 32'(bad), 32'd0);
    chk("t5_no_bytes", 32'(seen_bytes - sb), 32'd0);
    hold = 1'b0;
    wait_idle(1000);
    chk("t5_bytes", 32'(seen_bytes - sb), 32'd4);

    // 6: async reset in WAIT_IDLE, then a clean block
    gap_fixed = 8;
    sb = seen_bytes;
    issue_block(1'b1, 32, 32'h01020304, 1'b0);
    for (int i = 0; i < 200 && seen_bytes < sb + 2; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("t6_start_out", 32'(start_out), 32'd0);
    chk("t6_data_out", 32'(data_out), 32'd0);
    chk("t6_eot_done", 32'(eot_done), 32'd0);
    chk("t6_busy", 32'(busy), 32'd0);
    m_clear();
    exp_q.delete();
    exp_eot = 0;
    repeat (12) @(negedge clk);
    rst = 1'b0;
    gap_fixed = 0;
    sb = seen_bytes;
    issue_block(1'b1, 32, 32'hDEADBEEF, 1'b0);
    wait_idle(500);
    chk("t6_bytes", 32'(seen_bytes - sb), 32'd4);

    // Randomised traffic against the bit-stream model
    for (int it = 0; it < 60; it++) begin
      int r, nl;
      logic md, es;
      r = int'($urandom_range(0, 99));
      if (r < 8) begin
        issue_start();
        chk("start_data_out", 32'(data_out), 32'd0);
        chk("start_busy", 32'(busy), 32'd0);
      end else if (r < 16) begin
        issue_eot();
      end else begin
        md = 1'($urandom_range(0, 1));
        nl = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 1))
                                         : int'($urandom_range(2, 32));
        es = ($urandom_range(0, 5) == 0);
        issue_block(md, nl, $urandom, es);
        if (!es && $urandom_range(0, 5) == 0) begin
          repeat ($urandom_range(0, 20)) @(negedge clk);
          issue_eot();
        end
      end
      wait_idle(3000);
    end

    // start while shifting aborts without a byte
    issue_start();
    sb = seen_bytes;
    issue_block(1'b1, 32, 32'hCAFEF00D, 1'b0);
    repeat (2) @(negedge clk);
    issue_start();
    repeat (20) @(negedge clk);
    chk("abort_no_bytes", 32'(seen_bytes - sb), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);

    wait_idle(1000);
    chk("final_queue", 32'(exp_q.size()), 32'd0);
    chk("final_eot", 32'(exp_eot), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/crypter_out_packer.md
Name: crypter_out_packer

Overview:
- Downstream stage of the crypter. Consumes 32-bit FastModExp results and serialises them into bytes for the UART transmitter using a ready/start handshake.
- Encrypt mode (mode=1): every block is emitted as 32 bits, LSB first, giving 4 bytes per block.
- Decrypt mode (mode=0): only the low n_len-1 payload bits of each block are emitted, LSB first. This undoes the input-side packing, so the original byte stream is recovered.
- An end-of-transmission tick flushes any partial byte, zero-padded.

Parameters:
- BLK_W, 32, FME block width in bits.
- BYTE_W, 8, UART byte width.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- start  in  1  session-start tick; clears all internal state.
- mode  in  1  1 = encrypt, 0 = decrypt.
- n_len  in  6  bit length of n_key, valid 2..32.
- fme_result  in  32  FME result word.
- fme_done  in  1  one-cycle tick; fme_result is valid in the same cycle.
- eot  in  1  end-of-stream tick from the input side.
- busy  out  1  high whenever not in IDLE; upstream must not pulse fme_done while busy=1.
- ready_out  in  1  UART TX idle.
- start_out  out  1  one-cycle byte-send tick.
- data_out  out  8  byte to transmit; held stable from start_out until the next send.
- eot_done  out  1  one-cycle tick when the flush is complete.

Behaviour:
- Reset (async): state=IDLE; start_out=0, data_out=0x00, eot_done=0, busy=0; accumulator, counters and eot_pend cleared.
- bits_per_block = mode ? 32 : n_len-1. It is latched on fme_done.
- In decrypt mode, n_len<2 gives 0 bits: the block is accepted and discarded, and the FSM stays in IDLE.
- Internal registers:
  - blk_sr: 32-bit right-shift register.
  - bit_cnt: 0..32.
  - acc: 8-bit byte register.
  - acc_cnt: 0..8.
  - eot_pend flag.
- IDLE:
  - On fme_done: blk_sr<=fme_result, bit_cnt<=bits_per_block, go to SHIFT.
  - If eot arrives in the same cycle as fme_done, set eot_pend.
  - On eot alone: if acc_cnt>0 go to SEND with flush=1; otherwise pulse eot_done the next cycle.
- SHIFT: one bit per clock.
  - acc[acc_cnt]<=blk_sr[0]; blk_sr>>=1; acc_cnt++; bit_cnt--.
  - If acc_cnt reaches 8, go to SEND.
  - Else if bit_cnt reaches 0: if eot_pend go to FLUSH_CHK, otherwise go to IDLE.
- SEND:
  - Waits while ready_out=0.
  - When ready_out=1: start_out=1 for exactly one cycle, data_out<=acc with the unfilled upper bits forced to 0; acc and acc_cnt cleared; go to WAIT_BUSY.
- WAIT_BUSY: wait for ready_out=0, then go to WAIT_IDLE.
- WAIT_IDLE: wait for ready_out=1, then:
  - if bit_cnt>0, return to SHIFT;
  - else if flush or eot_pend, pulse eot_done, clear the flags and go to IDLE;
  - else go to IDLE.
- FLUSH_CHK (one cycle): if acc_cnt>0 go to SEND with flush=1; else pulse eot_done and go to IDLE.
- eot received while busy=1 only sets eot_pend; it is never lost.
- start in any state: synchronous abort to IDLE, all registers cleared, no start_out issued.
- fme_done while busy=1 is a protocol violation and is ignored.
- Latency (encrypt, UART always idle): fme_done to first start_out = 1 (load) + 8 (shift) + 1 = 10 cycles.
- Byte boundaries carry across blocks: acc_cnt is not cleared between blocks, only on send, start or reset.

Decomposition:
- Package crypt_pkg holds:
  - the state enum {IDLE, SHIFT, SEND, WAIT_BUSY, WAIT_IDLE, FLUSH_CHK};
  - BLK_W=32 and BYTE_W=8;
  - constant MIN_NLEN=2.
- One natural sub-module, byte_assembler. It owns acc and acc_cnt with the ports bit_in, shift_en, clear, full and byte. The top level keeps the FSM, blk_sr and bit_cnt.

Test Plan:
1. mode=1, fme_result=0x11223344, UART returns to ready 5 cycles after each start_out → bytes 0x44, 0x33, 0x22, 0x11 in order; busy drops after the 4th handshake.
2. mode=0, n_len=9, result 0x000000A5 → exactly one byte 0xA5; no eot_done.
3. mode=0, n_len=5, blocks 0x3 then 0xC, then eot → single byte 0xC3; eot_done one cycle after that byte's handshake completes.
4. mode=0, n_len=5, block 0x7 with eot in the same cycle as fme_done → flush byte 0x07, then eot_done pulse.
5. ready_out held 0 for 200 cycles during SEND → no start_out, busy=1, data_out unchanged; release → exactly one start_out.
6. rst asserted mid-WAIT_IDLE after 2 of 4 encrypt bytes → all outputs 0 immediately; a new block 0xDEADBEEF → bytes 0xEF, 0xBE, 0xAD, 0xDE with no residual bits.
